// File: rtl/uart_6809_fifo.sv
// rtl/uart_6809_fifo.sv - 6809-bus 8N1 UART with 16x receiver, RX FIFO, control/status and maskable IRQ
module uart_6809_fifo #(
    parameter int BAUD_DIV = 289,
    parameter int FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_data_ce,
    input  logic       uart_status_ce,
    input  logic       uart_control_ce,
    input  logic       i_RW,
    input  logic [7:0] i_DATA_BUS,
    input  logic       i_UART_TX,
    output logic       o_UART_RX,
    output logic [7:0] o_DATA,
    output logic       o_IRQ
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] FIFO_FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          data_ce_q, status_ce_q, control_ce_q;
    logic          data_acc, status_acc, control_acc;
    logic          data_rd, data_wr, status_rd, control_rd, control_wr, flush;
    logic          rx_ie, tx_ie, loop_en;
    logic          ovr_flag, fe_flag;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count;
    logic               rx_avail, rx_full, push, pop;

    rx_state_t  rx_state;
    logic       rx_sync1, rx_sync2, rx_in, rx_wait_high;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       stop_sample, rx_push, ovr_set, fe_set;

    tx_state_t  tx_state;
    logic [7:0] tx_hold;
    logic       tx_hold_full, tx_rdy, tx_line, tx_load, tx_frame_end;
    logic [8:0] tx_shift;
    logic [3:0] tx_tcnt;
    logic [3:0] tx_bit;

    logic       irq_pend;
    logic [7:0] status_byte;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running oversample tick shared by RX and TX
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Each chip enable acts only on its first asserted cycle; data beats status beats control
    assign data_acc    = uart_data_ce & ~data_ce_q;
    assign status_acc  = uart_status_ce & ~status_ce_q & ~data_acc;
    assign control_acc = uart_control_ce & ~control_ce_q & ~data_acc & ~status_acc;
    assign data_rd     = data_acc & i_RW;
    assign data_wr     = data_acc & ~i_RW;
    assign status_rd   = status_acc & i_RW;
    assign control_rd  = control_acc & i_RW;
    assign control_wr  = control_acc & ~i_RW;
    assign flush       = control_wr & i_DATA_BUS[2];

    // Previous-cycle enables for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_ce_q    <= 1'b0;
            status_ce_q  <= 1'b0;
            control_ce_q <= 1'b0;
        end else begin
            data_ce_q    <= uart_data_ce;
            status_ce_q  <= uart_status_ce;
            control_ce_q <= uart_control_ce;
        end
    end

    // Control register; FLUSH is a one-shot and never stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
            loop_en <= 1'b0;
        end else if (control_wr) begin
            rx_ie   <= i_DATA_BUS[0];
            tx_ie   <= i_DATA_BUS[1];
            loop_en <= i_DATA_BUS[3];
        end
    end

    assign rx_avail = (fifo_count != '0);
    assign rx_full  = (fifo_count == FIFO_FULL_CNT);
    assign pop      = data_rd & rx_avail;
    assign push     = rx_push & ~flush;

    // FIFO storage (no reset needed; contents are only visible through the count)
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_shift;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous host line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= i_UART_TX;
            rx_sync2 <= rx_sync1;
        end
    end

    assign rx_in       = loop_en ? tx_line : rx_sync2;
    assign stop_sample = (rx_state == RX_STOP) && tick && (rx_tcnt == 4'd15);
    assign rx_push     = stop_sample & rx_in & ~rx_full;
    assign ovr_set     = stop_sample & rx_in & rx_full;
    assign fe_set      = stop_sample & ~rx_in;

    // Receiver: mid-bit sampling at 8 ticks into start, then every 16 ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_tcnt      <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_tcnt <= '0;
                    if (rx_wait_high) begin
                        if (rx_in) rx_wait_high <= 1'b0;
                    end else if (tick && !rx_in) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: if (tick) begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
                RX_DATA: if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt  <= '0;
                        rx_shift <= {rx_in, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
                RX_STOP: if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (!rx_in) rx_wait_high <= 1'b1;
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sticky error flags; a flag raised in the same cycle as the status read survives it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_flag <= 1'b0;
            fe_flag  <= 1'b0;
        end else begin
            ovr_flag <= ovr_set | (ovr_flag & ~status_rd);
            fe_flag  <= fe_set | (fe_flag & ~status_rd);
        end
    end

    assign tx_rdy       = ~tx_hold_full;
    assign tx_frame_end = (tx_state == TX_SHIFT) && tick && (tx_tcnt == 4'd15) && (tx_bit == 4'd9);
    assign tx_load      = tx_hold_full && tick && ((tx_state == TX_IDLE) || tx_frame_end);

    // Transmitter: holding register feeds the shifter on a tick, back-to-back if refilled in time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state     <= TX_IDLE;
            tx_hold      <= '0;
            tx_hold_full <= 1'b0;
            tx_shift     <= '1;
            tx_tcnt      <= '0;
            tx_bit       <= '0;
            tx_line      <= 1'b1;
        end else begin
            if (data_wr && !tx_hold_full) begin
                tx_hold      <= i_DATA_BUS;
                tx_hold_full <= 1'b1;
            end
            if (tx_load) begin
                tx_state     <= TX_SHIFT;
                tx_line      <= 1'b0;
                tx_shift     <= {1'b1, tx_hold};
                tx_hold_full <= 1'b0;
                tx_tcnt      <= '0;
                tx_bit       <= '0;
            end else if (tx_state == TX_SHIFT && tick) begin
                if (tx_tcnt == 4'd15) begin
                    tx_tcnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_state <= TX_IDLE;
                        tx_line  <= 1'b1;
                    end else begin
                        tx_line  <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[8:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_tcnt <= tx_tcnt + 1'b1;
                end
            end
        end
    end

    assign o_UART_RX   = loop_en ? 1'b1 : tx_line;
    assign irq_pend    = (rx_ie & (rx_avail | ovr_flag | fe_flag)) | (tx_ie & tx_rdy);
    assign status_byte = {irq_pend, 2'b00, rx_full, fe_flag, ovr_flag, tx_rdy, rx_avail};

    // Read data and interrupt line, both registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_DATA <= 8'h00;
            o_IRQ  <= 1'b1;
        end else begin
            o_IRQ <= ~irq_pend;
            if (data_rd)         o_DATA <= rx_avail ? fifo_mem[rd_ptr] : 8'h00;
            else if (status_rd)  o_DATA <= status_byte;
            else if (control_rd) o_DATA <= {4'b0000, loop_en, 1'b0, tx_ie, rx_ie};
        end
    end
endmodule

// File: tb/tb_uart_6809_fifo.sv
// tb/tb_uart_6809_fifo.sv - randomized scoreboard bench for uart_6809_fifo
module tb_uart_6809_fifo;
    localparam int BAUD_DIV = 4;
    localparam int FIFO_AW  = 4;
    localparam int DEPTH    = 16;
    localparam int BIT_CLK  = 16 * BAUD_DIV;
    localparam int FRAME    = 10 * BIT_CLK;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_data_ce = 1'b0, uart_status_ce = 1'b0, uart_control_ce = 1'b0;
    logic       i_RW = 1'b1;
    logic [7:0] i_DATA_BUS = 8'h00;
    logic       i_UART_TX = 1'b1;
    logic       o_UART_RX;
    logic [7:0] o_DATA;
    logic       o_IRQ;

    uart_6809_fifo #(.BAUD_DIV(BAUD_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset(reset),
        .uart_data_ce(uart_data_ce), .uart_status_ce(uart_status_ce),
        .uart_control_ce(uart_control_ce), .i_RW(i_RW), .i_DATA_BUS(i_DATA_BUS),
        .i_UART_TX(i_UART_TX), .o_UART_RX(o_UART_RX), .o_DATA(o_DATA), .o_IRQ(o_IRQ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0, n_fail = 0;
    logic       rd_fire = 1'b0;
    int         rst_epoch = 0;
    logic [7:0] rd_exp[$];
    logic [7:0] tx_exp[$];

    // Reference model: byte queue for the FIFO, flags, and a TX line timeline
    logic [7:0] m_fifo[$];
    logic [7:0] m_loop_pending[$];
    bit         m_ovr, m_fe, m_rx_ie, m_tx_ie, m_loop;
    int         m_hold_empty_at = 0, m_line_free_at = 0;

    function automatic bit m_tx_rdy();
        return cyc >= m_hold_empty_at;
    endfunction

    function automatic bit m_irq();
        return (m_rx_ie && (m_fifo.size() != 0 || m_ovr || m_fe)) || (m_tx_ie && m_tx_rdy());
    endfunction

    function automatic logic [7:0] m_status();
        return {m_irq(), 2'b00, m_fifo.size() == DEPTH, m_fe, m_ovr, m_tx_rdy(), m_fifo.size() != 0};
    endfunction

    function automatic void model_rx_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                 m_fe = 1'b1;
        else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
        else                          m_ovr = 1'b1;
    endfunction

    function automatic void model_reset();
        m_fifo.delete(); m_loop_pending.delete(); tx_exp.delete();
        m_ovr = 0; m_fe = 0; m_rx_ie = 0; m_tx_ie = 0; m_loop = 0;
        m_hold_empty_at = 0; m_line_free_at = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_irq(input string name);
        check(name, {31'd0, o_IRQ}, {31'd0, !m_irq()});
    endtask

    task automatic bus_cycle(input int sel, input bit rw, input logic [7:0] d);
        @(negedge clk);
        uart_data_ce    = (sel == 0);
        uart_status_ce  = (sel == 1);
        uart_control_ce = (sel == 2);
        i_RW = rw; i_DATA_BUS = d; rd_fire = rw;
        @(negedge clk);
        uart_data_ce = 0; uart_status_ce = 0; uart_control_ce = 0; rd_fire = 0;
    endtask

    task automatic data_read();
        if (m_fifo.size() != 0) rd_exp.push_back(m_fifo.pop_front());
        else                    rd_exp.push_back(8'h00);
        bus_cycle(0, 1'b1, 8'h00);
    endtask

    task automatic status_read();
        rd_exp.push_back(m_status());
        m_ovr = 0; m_fe = 0;
        bus_cycle(1, 1'b1, 8'h00);
    endtask

    task automatic control_read();
        rd_exp.push_back({4'b0000, m_loop, 1'b0, m_tx_ie, m_rx_ie});
        bus_cycle(2, 1'b1, 8'h00);
    endtask

    task automatic control_write(input logic [7:0] d);
        m_rx_ie = d[0]; m_tx_ie = d[1]; m_loop = d[3];
        if (d[2]) m_fifo.delete();
        bus_cycle(2, 1'b0, d);
    endtask

    task automatic data_write(input logic [7:0] d);
        if (m_tx_rdy()) begin
            if (cyc >= m_line_free_at) begin
                m_hold_empty_at = cyc + 4;
                m_line_free_at  = cyc + 4 + FRAME;
            end else begin
                m_hold_empty_at = m_line_free_at;
                m_line_free_at  = m_line_free_at + FRAME;
            end
            if (m_loop) m_loop_pending.push_back(d);
            else        tx_exp.push_back(d);
        end
        bus_cycle(0, 1'b0, d);
    endtask

    task automatic host_send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_UART_TX = fr[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        i_UART_TX = 1'b1;
        model_rx_frame(b, stop_ok);
    endtask

    // Read monitor: o_DATA is compared one clock after every read access
    initial begin
        forever begin
            @(posedge clk);
            if (rd_fire) begin
                @(negedge clk);
                if (rd_exp.size() == 0) check("read_unexpected", {24'd0, o_DATA}, 32'hFFFF_FFFF);
                else                    check("read_data", {24'd0, o_DATA}, {24'd0, rd_exp.pop_front()});
            end
        end
    end

    // Serial monitor: decodes frames on o_UART_RX at mid-bit
    initial begin
        forever begin
            logic [9:0] fr;
            int ep;
            @(negedge o_UART_RX);
            ep = rst_epoch;
            repeat (BIT_CLK / 2) @(negedge clk);
            fr[0] = o_UART_RX;
            for (int i = 1; i < 10; i++) begin
                repeat (BIT_CLK) @(negedge clk);
                fr[i] = o_UART_RX;
            end
            if (ep == rst_epoch) begin
                if (tx_exp.size() == 0) check("tx_unexpected_frame", {22'd0, fr}, 32'hFFFF_FFFF);
                else check("tx_frame", {22'd0, fr}, {22'd0, 1'b1, tx_exp.pop_front(), 1'b0});
            end
        end
    end

    initial begin
        logic [7:0] b, w;
        int lows;

        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("reset_line", {31'd0, o_UART_RX}, 32'd1);
        check("reset_data", {24'd0, o_DATA}, 32'd0);
        check("reset_irq", {31'd0, o_IRQ}, 32'd1);
        status_read();
        control_read();

        // Host byte with RX interrupt enabled
        control_write(8'h01);
        check_irq("irq_idle");
        host_send(8'hA5, 1'b1);
        check_irq("irq_rx_avail");
        status_read();
        data_read();
        repeat (2) @(negedge clk);
        check_irq("irq_after_read");

        // Transmit 0x3C, refill during the frame, third write rejected while holding is full
        data_write(8'h3C);
        repeat (40) @(negedge clk);
        w = 8'($urandom);
        data_write(w);
        repeat (20) @(negedge clk);
        status_read();
        data_write(~w);
        repeat (1400) @(negedge clk);
        status_read();
        control_write(8'h03);
        repeat (2) @(negedge clk);
        check_irq("irq_tx_rdy");
        status_read();
        control_write(8'h01);

        // Overflow: 17 frames with no reads
        for (int i = 0; i < DEPTH + 1; i++) host_send(8'($urandom), 1'b1);
        status_read();
        status_read();
        for (int i = 0; i < DEPTH; i++) data_read();
        data_read();

        // Framing error, then a short glitch, then a clean byte
        host_send(8'($urandom), 1'b0);
        repeat (2) @(negedge clk);
        check_irq("irq_fe");
        status_read();
        status_read();
        i_UART_TX = 1'b0;
        repeat (4) @(negedge clk);
        i_UART_TX = 1'b1;
        repeat (700) @(negedge clk);
        status_read();
        data_read();
        host_send(8'($urandom), 1'b1);
        data_read();

        // Loopback
        control_write(8'h09);
        data_write(8'h81);
        lows = 0;
        repeat (720) begin
            @(negedge clk);
            if (o_UART_RX !== 1'b1) lows++;
        end
        check("loop_line_high", lows, 0);
        while (m_loop_pending.size() != 0) model_rx_frame(m_loop_pending.pop_front(), 1'b1);
        data_read();
        data_write(8'($urandom));
        repeat (720) @(negedge clk);
        while (m_loop_pending.size() != 0) model_rx_frame(m_loop_pending.pop_front(), 1'b1);
        status_read();
        control_write(8'h0D);
        status_read();
        control_read();
        control_write(8'h01);

        // Full duplex with random bytes
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            w = 8'($urandom);
            fork
                host_send(b, 1'b1);
                data_write(w);
            join
            repeat (40) @(negedge clk);
            data_read();
            repeat (2) @(negedge clk);
            check_irq("irq_duplex");
        end

        // Enable held for 5 cycles pops exactly one byte
        for (int i = 0; i < 3; i++) host_send(8'($urandom), 1'b1);
        rd_exp.push_back(m_fifo.pop_front());
        @(negedge clk);
        uart_data_ce = 1; i_RW = 1; rd_fire = 1;
        @(negedge clk);
        rd_fire = 0;
        repeat (4) @(negedge clk);
        uart_data_ce = 0;
        data_read();
        data_read();
        data_read();

        // Reset in the middle of a transmitted frame
        control_write(8'h03);
        data_write(8'($urandom));
        repeat (200) @(negedge clk);
        reset = 1;
        #1;
        rst_epoch++;
        model_reset();
        check("midreset_line", {31'd0, o_UART_RX}, 32'd1);
        check("midreset_irq", {31'd0, o_IRQ}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 0;
        status_read();
        control_read();
        repeat (700) @(negedge clk);
        check("post_reset_line", {31'd0, o_UART_RX}, 32'd1);
        check("rd_queue_drained", rd_exp.size(), 0);
        check("tx_queue_drained", tx_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_6809_fifo.md
Name: uart_6809_fifo

Overview:
Second-generation 6809-bus UART between the CPU register decode and the FT2232 serial lines. It provides full-duplex 8N1 with a 16x-oversampled receiver and a parametrised RX FIFO. The transmitter has a holding register and shift register. It adds a control register (interrupt enables, FIFO flush, loopback) and a status register with sticky error flags. The active-low IRQ is maskable.

Parameters:
BAUD_DIV, 289, clk cycles per oversample tick (44.33 MHz / (16*9600)); bit period = 16*BAUD_DIV clk
FIFO_AW, 4, RX FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
uart_data_ce  in  1  data register select
uart_status_ce  in  1  status register select
uart_control_ce  in  1  control register select
i_RW  in  1  1 = read, 0 = write
i_DATA_BUS  in  8  write data from the 6809
i_UART_TX  in  1  serial in from host, idle high
o_UART_RX  out  1  serial out to host, idle high
o_DATA  out  8  read data to the 6809
o_IRQ  out  1  interrupt, active low

Behaviour:
- Reset values:
  - o_UART_RX=1, o_DATA=0x00, o_IRQ=1.
  - Control register=0x00; FIFO empty; OVR/FE clear; TX idle and holding register empty.
  - Tick counter and RX state return to IDLE.
- Bus access:
  - Acts only on the first clk cycle a chip enable is high (the enable was low the previous cycle). Holding an enable asserted has no further effect.
  - If several enables rise together, priority is data > status > control.
  - o_DATA updates one clk after the access cycle and holds until the next read.
- Data read:
  - FIFO non-empty: o_DATA = head byte and the FIFO pops.
  - FIFO empty: o_DATA = 0x00; pointers unchanged.
- Data write:
  - TX_RDY=1: byte goes to the holding register and TX_RDY=0 next cycle.
  - TX_RDY=0: write is ignored.
- Status read: o_DATA = {IRQ_PEND, 0, 0, RX_FULL, FE, OVR, TX_RDY, RX_AVAIL}. OVR and FE clear after the read. A flag set in the same cycle as the read survives.
- Control register:
  - Write: bit0 RX_IE, bit1 TX_IE, bit3 LOOP are stored.
  - Bit2 FLUSH empties the FIFO in that cycle and is not stored.
  - Read returns {4'b0, LOOP, 0, TX_IE, RX_IE}.
- Tick generator: free-running counter 0..BAUD_DIV-1; tick = 1 clk pulse at wrap. RX and TX share it.
- RX path:
  - Input is i_UART_TX through a 2-flop synchroniser. When LOOP=1 the TX shifter output is used instead.
  - States: IDLE, START, DATA, STOP.
  - IDLE -> START on a sampled low.
  - START: sample after 8 ticks. Still low -> DATA; high -> IDLE (false start, nothing recorded).
  - DATA: 8 bits, each sampled 16 ticks apart, LSB first.
  - STOP: sample 16 ticks later.
    - High and FIFO not full: push the byte.
    - High and FIFO full: OVR=1, byte dropped, FIFO unchanged.
    - Low: FE=1, byte dropped. RX then waits in IDLE for line high before re-arming.
- FIFO:
  - Push and pop in the same cycle both happen; count is unchanged.
  - Pop on empty is a no-op; pointers wrap modulo depth.
  - RX_AVAIL = count!=0; RX_FULL = count==depth.
- TX path:
  - States: IDLE, SHIFT.
  - In IDLE with holding full, the next tick loads the shifter and sets TX_RDY=1.
  - Frame is start 0, 8 data LSB first, stop 1; each bit lasts 16 ticks. Then return to IDLE.
  - If holding is already refilled, the next frame starts with no idle gap.
  - When LOOP=1, o_UART_RX is forced high and the frame goes internally to RX.
- IRQ:
  - IRQ_PEND = (RX_IE & (RX_AVAIL|OVR|FE)) | (TX_IE & TX_RDY).
  - o_IRQ = ~IRQ_PEND, registered (1 clk latency).
- Reset mid-frame aborts RX and TX immediately; o_UART_RX returns high asynchronously.

Test Plan:
- BAUD_DIV=4; host sends 0xA5 8N1 at 64 clk/bit -> RX_AVAIL=1, o_IRQ low 1 clk after push with RX_IE=1; data read returns 0xA5, o_IRQ returns high.
- Write 0x3C with TX idle -> o_UART_RX shows 0,0,0,1,1,1,1,0,0,1, each 64 clk; TX_RDY=0 then 1 after load; second write during the frame follows back-to-back.
- Send 17 bytes 0x00..0x10 with no reads (FIFO_AW=4) -> RX_FULL=1, OVR=1; 16 reads return 0x00..0x0F; status read clears OVR.
- Frame 0x55 with stop bit low -> FE=1, FIFO empty, no push; 4-clk low glitch -> no state change.
- LOOP=1, write 0x81 -> o_UART_RX stays 1, FIFO receives 0x81; FLUSH write -> RX_AVAIL=0.
- Assert reset mid-TX-frame -> o_UART_RX=1, o_IRQ=1, TX_RDY=1, control=0x00; enable held 5 cycles on a 3-byte FIFO pops exactly one byte.
